// File: rtl/axil_cfg_arbiter.sv
// rtl/axil_cfg_arbiter.sv - round-robin two-requester AXI4-Lite master, one transaction at a time.
// Optional stall timeout built only when AXIL_CFG_ARB_TIMEOUT_EN is defined.
module axil_cfg_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,
  input  logic [1:0]  REQ_VALID,
  output logic [1:0]  REQ_READY,
  input  logic [1:0]  REQ_WRITE,
  input  logic [13:0] REQ_ADDR,
  input  logic [63:0] REQ_WDATA,
  input  logic [7:0]  REQ_WSTRB,
  output logic [1:0]  RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic [1:0]  RSP_RESP,
  output logic        STALL_ERR,
  output logic [6:0]  M_AXI_AWADDR,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [6:0]  M_AXI_ARADDR,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RA, S_RR, S_RSP} state_t;

  state_t      state, state_n;
  logic        last, grant, owner;
  logic        aw_done, w_done;
  logic [6:0]  addr_q;
  logic [31:0] wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  resp_q;

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign RSP_RDATA    = rdata_q;
  assign RSP_RESP     = resp_q;

  // On a tie the requester that did not win last time gets the slot.
  assign grant = (&REQ_VALID) ? ~last : REQ_VALID[1];

  always_comb begin
    state_n       = state;
    REQ_READY     = 2'b00;
    RSP_VALID     = 2'b00;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (state)
      S_IDLE: begin
        if ((|REQ_VALID) && !S_AXI_ARESET) begin
          REQ_READY[grant] = 1'b1;
          state_n = REQ_WRITE[grant] ? S_WR : S_RA;
        end
      end
      S_WR: begin
        M_AXI_AWVALID = !aw_done;
        M_AXI_WVALID  = !w_done;
        if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY))
          state_n = S_WB;
      end
      S_WB: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) state_n = S_RSP;
      end
      S_RA: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) state_n = S_RR;
      end
      S_RR: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) state_n = S_RSP;
      end
      S_RSP: begin
        RSP_VALID[owner] = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state   <= S_IDLE;
      last    <= 1'b1;
      owner   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (|REQ_VALID) begin
            last    <= grant;
            owner   <= grant;
            addr_q  <= grant ? REQ_ADDR[13:7]   : REQ_ADDR[6:0];
            wdata_q <= grant ? REQ_WDATA[63:32] : REQ_WDATA[31:0];
            wstrb_q <= grant ? REQ_WSTRB[7:4]   : REQ_WSTRB[3:0];
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        S_WR: begin
          if (M_AXI_AWREADY) aw_done <= 1'b1;
          if (M_AXI_WREADY)  w_done  <= 1'b1;
        end
        S_WB: begin
          if (M_AXI_BVALID) begin
            rdata_q <= '0;
            resp_q  <= M_AXI_BRESP;
          end
        end
        S_RR: begin
          if (M_AXI_RVALID) begin
            rdata_q <= M_AXI_RDATA;
            resp_q  <= M_AXI_RRESP;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AXIL_CFG_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        stall_q;

  assign STALL_ERR = stall_q;

  // Counts cycles spent waiting on the slave; the flag fires as the count reaches the limit.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      tmo_cnt <= '0;
      stall_q <= 1'b0;
    end else if (state == S_IDLE) begin
      tmo_cnt <= '0;
    end else if (state != S_RSP) begin
      if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
      if ((32'(tmo_cnt) + 32'd1) == TIMEOUT_CYCLES) stall_q <= 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign STALL_ERR  = 1'b0;
`endif

endmodule
